// File: rtl/data_ram_pipelined_if.sv
// Request/response bundle for the MEM-stage data RAM: valid/ready requests in,
// fixed-latency responses out; init_done reports completion of the zero-fill sweep.
interface data_ram_pipelined_if #(
  parameter int DATA_W = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_re;
  logic                  req_we;
  logic [15:0]           req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_data;
  logic                  init_done;

  modport master (
    output req_valid, req_re, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_data, init_done
  );

  modport slave (
    input  req_valid, req_re, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_data, init_done
  );
endinterface

// File: rtl/data_ram_pipelined.sv
// Byte-enabled synchronous data RAM with zero-fill sweep after reset; responses
// leave RD_LAT cycles after accept, in order; req_ready low only during the sweep.
module data_ram_pipelined #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 8,
  parameter int RD_LAT    = 1,
  parameter int PASS_ADDR = 1
) (
  input  logic                clk,
  input  logic                rst,
  data_ram_pipelined_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int NBYTE = DATA_W / 8;

  generate
    if (RD_LAT < 1 || RD_LAT > 4) begin : gBadLat
      $error("data_ram_pipelined: RD_LAT must be in 1..4, got %0d", RD_LAT);
    end
    if (DATA_W < 8 || (DATA_W % 8) != 0) begin : gBadWidth
      $error("data_ram_pipelined: DATA_W must be a positive multiple of 8, got %0d", DATA_W);
    end
    if (ADDR_W < 1 || ADDR_W > 16) begin : gBadAddr
      $error("data_ram_pipelined: ADDR_W must be in 1..16, got %0d", ADDR_W);
    end
  endgenerate

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t              state;
  state_t              stateNext;
  logic [ADDR_W-1:0]   initPtr;
  logic                reqReady;
  logic                initDone;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                accept;
  logic                rspIssue;
  logic [ADDR_W-1:0]   wordAddr;
  logic [DATA_W-1:0]   passData;

  logic [RD_LAT-1:0]   pipeVld;
  logic [DATA_W-1:0]   pipeDat [RD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= INIT;
      initPtr <= '0;
    end else begin
      state <= stateNext;
      if (state == INIT) begin
        initPtr <= initPtr + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      INIT:    if (&initPtr) stateNext = RUN;
      RUN:     stateNext = RUN;
      default: stateNext = INIT;
    endcase
  end

  always_comb begin
    reqReady = 1'b0;
    initDone = 1'b0;
    if (state == RUN) begin
      reqReady = 1'b1;
      initDone = 1'b1;
    end
  end

  // A request presented in the reset cycle is dropped even if the FSM still reads RUN.
  assign accept   = bus.req_valid & reqReady & ~rst;
  assign wordAddr = bus.req_addr[ADDR_W-1:0];
  assign passData = DATA_W'(bus.req_addr);
  assign rspIssue = accept & (bus.req_re | (PASS_ADDR != 0));

  always_ff @(posedge clk) begin
    if (!rst && state == INIT) begin
      mem[initPtr] <= '0;
    end else if (accept && bus.req_we) begin
      for (int i = 0; i < NBYTE; i++) begin
        if (bus.req_be[i]) begin
          mem[wordAddr][8*i +: 8] <= bus.req_wdata[8*i +: 8];
        end
      end
    end
  end

  // Stage 0 samples mem at the accept edge, so a same-edge write is not visible (read-first).
  // Each stage only loads on valid input, which keeps rsp_data stable between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipeVld <= '0;
      for (int s = 0; s < RD_LAT; s++) begin
        pipeDat[s] <= '0;
      end
    end else begin
      pipeVld[0] <= rspIssue;
      if (rspIssue) begin
        pipeDat[0] <= bus.req_re ? mem[wordAddr] : passData;
      end
      for (int s = 1; s < RD_LAT; s++) begin
        pipeVld[s] <= pipeVld[s-1];
        if (pipeVld[s-1]) begin
          pipeDat[s] <= pipeDat[s-1];
        end
      end
    end
  end

  assign bus.req_ready = reqReady;
  assign bus.init_done = initDone;
  assign bus.rsp_valid = pipeVld[RD_LAT-1];
  assign bus.rsp_data  = pipeDat[RD_LAT-1];
endmodule

// File: tb/tb_data_ram_pipelined.sv
// Drives two RAM instances (RD_LAT=1 with pass-through, RD_LAT=3 without) with the
// same requests and checks both against an array/queue reference model.
module tb_data_ram_pipelined;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_ram_pipelined_if #(.DATA_W(16)) b1 ();
  data_ram_pipelined_if #(.DATA_W(16)) b3 ();

  data_ram_pipelined #(.DATA_W(16), .ADDR_W(8), .RD_LAT(1), .PASS_ADDR(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  data_ram_pipelined #(.DATA_W(16), .ADDR_W(8), .RD_LAT(3), .PASS_ADDR(0)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (b3)
  );

  typedef struct {
    int          due;
    logic [15:0] dat;
  } exp_t;

  exp_t        q1[$];
  exp_t        q3[$];
  logic [15:0] refMem [DEPTH];
  logic [15:0] last1 = '0;
  logic [15:0] last3 = '0;
  logic        expRdy = 1'b0;
  int          nChecks = 0;
  int          nFail = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic monOne(input int id, input logic v, input logic [15:0] d);
    exp_t        e;
    logic        expV;
    int          n;
    logic [15:0] last;
    e.due = -1;
    e.dat = '0;
    n     = (id == 1) ? q1.size() : q3.size();
    last  = (id == 1) ? last1 : last3;
    if (n > 0) e = (id == 1) ? q1[0] : q3[0];
    expV = (n > 0) && (e.due == cyc);
    checkVal($sformatf("d%0d_rsp_valid", id), {31'b0, v}, {31'b0, expV});
    if (expV) begin
      if (id == 1) void'(q1.pop_front());
      else         void'(q3.pop_front());
    end
    if (v) begin
      if (expV) checkVal($sformatf("d%0d_rsp_data", id), {16'b0, d}, {16'b0, e.dat});
      last = expV ? e.dat : d;
    end else begin
      checkVal($sformatf("d%0d_rsp_hold", id), {16'b0, d}, {16'b0, last});
    end
    if (id == 1) last1 = last;
    else         last3 = last;
  endtask

  task automatic step();
    @(negedge clk);
    monOne(1, b1.rsp_valid, b1.rsp_data);
    monOne(3, b3.rsp_valid, b3.rsp_data);
  endtask

  task automatic setPins(input logic v, input logic re, input logic we,
                         input logic [15:0] a, input logic [15:0] wd, input logic [1:0] be);
    b1.req_valid = v;  b1.req_re = re; b1.req_we = we;
    b1.req_addr  = a;  b1.req_wdata = wd; b1.req_be = be;
    b3.req_valid = v;  b3.req_re = re; b3.req_we = we;
    b3.req_addr  = a;  b3.req_wdata = wd; b3.req_be = be;
  endtask

  // Model: a request accepted at the coming edge answers after RD_LAT edges, read-first.
  task automatic drive(input logic v, input logic re, input logic we,
                       input logic [15:0] a, input logic [15:0] wd, input logic [1:0] be);
    exp_t e;
    setPins(v, re, we, a, wd, be);
    checkVal("d1_req_ready", {31'b0, b1.req_ready}, {31'b0, expRdy});
    checkVal("d3_req_ready", {31'b0, b3.req_ready}, {31'b0, expRdy});
    if (v && expRdy && !rst) begin
      e.dat = re ? refMem[a[7:0]] : a;
      e.due = cyc + 1;
      q1.push_back(e);
      if (re) begin
        e.due = cyc + 3;
        q3.push_back(e);
      end
      if (we && be[0]) refMem[a[7:0]][7:0]  = wd[7:0];
      if (we && be[1]) refMem[a[7:0]][15:8] = wd[15:8];
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
  endtask

  task automatic randReq();
    logic [15:0] a;
    a = 16'($urandom_range(0, 15));
    if ($urandom_range(0, 3) == 0) a[15:8] = 8'($urandom);
    drive($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), a, 16'($urandom), 2'($urandom));
  endtask

  task automatic applyReset(input int n);
    rst    = 1'b1;
    expRdy = 1'b0;
    q1.delete();
    q3.delete();
    last1 = '0;
    last3 = '0;
    for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
    for (int i = 0; i < n; i++) begin
      step();
      checkVal("d1_init_done_rst", {31'b0, b1.init_done}, 32'd0);
      checkVal("d3_init_done_rst", {31'b0, b3.init_done}, 32'd0);
      randReq();
    end
  endtask

  task automatic runInit();
    int   fall;
    logic doneExp;
    fall = cyc;
    rst  = 1'b0;
    for (int k = 0; k < DEPTH + 4; k++) begin
      step();
      doneExp = (cyc - fall) >= DEPTH;
      checkVal("d1_init_done", {31'b0, b1.init_done}, {31'b0, doneExp});
      checkVal("d3_init_done", {31'b0, b3.init_done}, {31'b0, doneExp});
      expRdy = doneExp;
      randReq();
    end
  endtask

  initial begin
    logic [15:0] zeroAddrs [3];
    zeroAddrs[0] = 16'h0000;
    zeroAddrs[1] = 16'h007F;
    zeroAddrs[2] = 16'h00FF;
    setPins(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);

    applyReset(3);
    runInit();
    repeat (4) begin step(); idle(); end

    foreach (zeroAddrs[i]) begin step(); drive(1'b1, 1'b1, 1'b0, zeroAddrs[i], 16'h0, 2'b00); end

    step(); drive(1'b1, 1'b0, 1'b1, 16'h0005, 16'hBEEF, 2'b11);
    step(); drive(1'b1, 1'b1, 1'b0, 16'h0005, 16'h0000, 2'b00);
    step(); drive(1'b1, 1'b0, 1'b1, 16'h0005, 16'h1234, 2'b01);
    step(); drive(1'b1, 1'b1, 1'b0, 16'h0005, 16'h0000, 2'b00);

    step(); drive(1'b1, 1'b0, 1'b1, 16'h0009, 16'hAAAA, 2'b11);
    step(); drive(1'b1, 1'b1, 1'b1, 16'h0009, 16'h5555, 2'b11);
    step(); drive(1'b1, 1'b1, 1'b0, 16'h0009, 16'h0000, 2'b00);

    for (int a = 1; a <= 8; a++) begin
      step(); drive(1'b1, 1'b1, 1'b0, 16'(a), 16'h0, 2'b00);
    end
    repeat (4) begin step(); idle(); end

    step(); drive(1'b1, 1'b0, 1'b0, 16'h0123, 16'hFFFF, 2'b11);
    step(); drive(1'b1, 1'b0, 1'b1, 16'h0105, 16'hCAFE, 2'b11);
    step(); drive(1'b1, 1'b1, 1'b0, 16'h0005, 16'h0000, 2'b00);
    step(); drive(1'b1, 1'b1, 1'b0, 16'hA705, 16'h0000, 2'b00);

    repeat (600) begin step(); randReq(); end
    repeat (5) begin step(); idle(); end

    // Reset with reads in flight in the RD_LAT=3 pipe.
    step(); drive(1'b1, 1'b0, 1'b1, 16'h0003, 16'h3C3C, 2'b11);
    step(); drive(1'b1, 1'b1, 1'b0, 16'h0003, 16'h0000, 2'b00);
    step(); drive(1'b1, 1'b1, 1'b0, 16'h0009, 16'h0000, 2'b00);
    step(); drive(1'b1, 1'b1, 1'b0, 16'h0005, 16'h0000, 2'b00);
    step();
    applyReset(2);
    runInit();
    repeat (3) begin step(); idle(); end

    step(); drive(1'b1, 1'b1, 1'b0, 16'h0003, 16'h0, 2'b00);
    step(); drive(1'b1, 1'b1, 1'b0, 16'h0005, 16'h0, 2'b00);
    step(); drive(1'b1, 1'b1, 1'b0, 16'h0009, 16'h0, 2'b00);
    for (int i = 0; i < 16; i++) begin
      step(); drive(1'b1, 1'b1, 1'b0, 16'($urandom_range(0, 255)), 16'h0, 2'b00);
    end
    repeat (6) begin step(); idle(); end

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
    $finish;
  end
endmodule
